// File: rtl/tri_dispatch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tri_dispatch_ctrl_pkg
//   Shared definitions for the triangle dispatch controller: triangle bus
//   geometry and the dispatch FSM state encoding.
// ---------------------------------------------------------------------------
package tri_dispatch_ctrl_pkg;

  // One vertex / one colour word, and the full {v1,v2,v3,c1,c2,c3} bus.
  localparam int VTX_W     = 96;
  localparam int COL_W     = 96;
  localparam int TRI_W_DEF = 3 * VTX_W + 3 * COL_W;

  // S_IDLE : looking for a ready triangle and a free engine.
  // S_WAIT : triangle just taken; assembler's tri_ready is stale until it drops.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/tri_dispatch_ctrl_rr_pick.sv
// ---------------------------------------------------------------------------
// tri_dispatch_ctrl_rr_pick
//   Combinational round-robin picker: grants the first requester at or after
//   ptr_i, wrapping cyclically.
// Ports:
//   req_i   [N]      request mask (free engines)
//   ptr_i   [IDX_W]  round-robin start position (must be < N)
//   grant_o [N]      one-hot grant (all zero when no request)
//   idx_o   [IDX_W]  index of the granted requester
//   any_o            at least one request present
// ---------------------------------------------------------------------------
module tri_dispatch_ctrl_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int k;

  // Scan offsets from farthest to nearest so the last hit written is the
  // closest requester at or after ptr_i.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    k       = 0;
    for (int j = N - 1; j >= 0; j--) begin
      k = (int'(ptr_i) + j) % N;
      if (req_i[k]) begin
        grant_o    = '0;
        grant_o[k] = 1'b1;
        idx_o      = IDX_W'(k);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// tri_dispatch_ctrl
//   Sequences the triangle assembler and dispatches each completed triangle
//   round-robin to one of NUM_RAST rasterizer engines. Tracks engine
//   occupancy, counts dispatched triangles and flags end-of-frame.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   tri_ready, tri_data assembler holds a complete triangle / its payload
//   dequeue             one-cycle pulse releasing the assembler's triangle
//   rast_busy           per-engine busy (rises the cycle after its start)
//   rast_start          one-hot one-cycle start strobe
//   rast_tri            registered triangle, stable until the next dispatch
//   eos, clear          end-of-stream pulse; synchronous clear of count/eos/frame
//   tri_count           triangles dispatched since reset/clear (wrapping)
//   frame_done          eos seen and everything drained; held until clear/rst
// ---------------------------------------------------------------------------
module tri_dispatch_ctrl
  import tri_dispatch_ctrl_pkg::*;
#(
  parameter int NUM_RAST = 2,
  parameter int TRI_W    = TRI_W_DEF,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tri_ready,
  input  logic [TRI_W-1:0]    tri_data,
  output logic                dequeue,
  input  logic [NUM_RAST-1:0] rast_busy,
  output logic [NUM_RAST-1:0] rast_start,
  output logic [TRI_W-1:0]    rast_tri,
  input  logic                eos,
  input  logic                clear,
  output logic [CNT_W-1:0]    tri_count,
  output logic                frame_done
);

  localparam int IDX_W = (NUM_RAST > 1) ? $clog2(NUM_RAST) : 1;

  state_e              state_q, state_d;
  logic [NUM_RAST-1:0] launched_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic                eos_seen_q;
  logic                dequeue_q;
  logic [NUM_RAST-1:0] rast_start_q;
  logic [TRI_W-1:0]    rast_tri_q;
  logic [CNT_W-1:0]    tri_count_q;
  logic                frame_done_q;

  logic [NUM_RAST-1:0] free_mask;
  logic [NUM_RAST-1:0] grant;
  logic [IDX_W-1:0]    sel;
  logic                any_free;
  logic                dispatch;
  logic                drained;
  logic [IDX_W-1:0]    rr_ptr_nxt;

  // An engine counts as occupied from its start strobe until it reports busy,
  // closing the one-cycle gap before the engine's busy flag appears.
  assign free_mask = ~rast_busy & ~launched_q;

  tri_dispatch_ctrl_rr_pick #(
    .N     (NUM_RAST),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (free_mask),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (sel),
    .any_o   (any_free)
  );

  assign rr_ptr_nxt = (sel == IDX_W'(NUM_RAST - 1)) ? '0 : sel + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    dispatch = 1'b0;
    drained  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tri_ready && any_free) begin
          dispatch = 1'b1;
          state_d  = S_WAIT;
        end else if (eos_seen_q && !tri_ready && !(|rast_busy) && !(|launched_q)) begin
          drained = 1'b1;
        end
      end
      // tri_ready still reflects the triangle just taken until the assembler
      // reacts to dequeue; never dispatch on it twice.
      S_WAIT: begin
        if (!tri_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      launched_q   <= '0;
      rr_ptr_q     <= '0;
      eos_seen_q   <= 1'b0;
      dequeue_q    <= 1'b0;
      rast_start_q <= '0;
      rast_tri_q   <= '0;
      tri_count_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      dequeue_q    <= dispatch;
      rast_start_q <= dispatch ? grant : '0;
      launched_q   <= (launched_q & ~rast_busy) | (dispatch ? grant : '0);
      if (dispatch) begin
        rast_tri_q <= tri_data;
        rr_ptr_q   <= rr_ptr_nxt;
      end
      if (clear) begin
        tri_count_q  <= dispatch ? CNT_W'(1) : '0;
        eos_seen_q   <= 1'b0;
        frame_done_q <= 1'b0;
      end else begin
        if (dispatch) tri_count_q  <= tri_count_q + CNT_W'(1);
        if (eos)      eos_seen_q   <= 1'b1;
        if (drained)  frame_done_q <= 1'b1;
      end
    end
  end

  assign dequeue    = dequeue_q;
  assign rast_start = rast_start_q;
  assign rast_tri   = rast_tri_q;
  assign tri_count  = tri_count_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tri_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tri_dispatch_ctrl
//   Randomized bench: behavioural assembler and engine models drive the DUT;
//   a reference model predicts every output each cycle. A narrow counter
//   makes the wrap-to-zero boundary occur many times per run.
// ---------------------------------------------------------------------------
module tb_tri_dispatch_ctrl;

  localparam int N      = 3;
  localparam int TW     = 576;
  localparam int CW     = 5;
  localparam int CYCLES = 8000;

  logic          clk = 1'b0;
  logic          rst;
  logic          tri_ready;
  logic [TW-1:0] tri_data;
  logic          dequeue;
  logic [N-1:0]  rast_busy;
  logic [N-1:0]  rast_start;
  logic [TW-1:0] rast_tri;
  logic          eos;
  logic          clear;
  logic [CW-1:0] tri_count;
  logic          frame_done;

  always #5 clk = ~clk;

  tri_dispatch_ctrl #(
    .NUM_RAST (N),
    .TRI_W    (TW),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tri_ready  (tri_ready),
    .tri_data   (tri_data),
    .dequeue    (dequeue),
    .rast_busy  (rast_busy),
    .rast_start (rast_start),
    .rast_tri   (rast_tri),
    .eos        (eos),
    .clear      (clear),
    .tri_count  (tri_count),
    .frame_done (frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model state
  bit            m_launched [N];
  bit            m_stale;
  int            m_ptr;
  int            m_count;
  bit            m_eos;
  bit            m_fd;
  bit            e_deq;
  logic [N-1:0]  e_start;
  logic [TW-1:0] e_tri;
  int            n_disp = 0;

  // Environment state
  int busy_left [N];
  bit pend      [N];
  bit deq_pend;
  int gap;
  int rst_hold;

  function automatic logic [TW-1:0] rand_tri();
    logic [TW-1:0] t;
    for (int w = 0; w < TW / 32; w++) t[w*32 +: 32] = $urandom;
    return t;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < N; e++) m_launched[e] = 1'b0;
    m_stale = 1'b0;
    m_ptr   = 0;
    m_count = 0;
    m_eos   = 1'b0;
    m_fd    = 1'b0;
    e_deq   = 1'b0;
    e_start = '0;
    e_tri   = '0;
  endtask

  // One clock edge of the dispatch rules, applied to the inputs just sampled.
  task automatic model_update();
    int sel;
    bit disp;
    bit any_launched;
    bit drained;
    sel = -1;
    any_launched = 1'b0;
    for (int e = 0; e < N; e++) any_launched |= m_launched[e];
    if (!m_stale && tri_ready) begin
      for (int j = 0; j < N; j++) begin
        int e;
        e = (m_ptr + j) % N;
        if (sel < 0 && !rast_busy[e] && !m_launched[e]) sel = e;
      end
    end
    disp    = (sel >= 0);
    drained = !m_stale && !disp && m_eos && !tri_ready && (rast_busy == '0) && !any_launched;
    for (int e = 0; e < N; e++)
      m_launched[e] = (m_launched[e] && !rast_busy[e]) || (disp && e == sel);
    m_stale = m_stale ? tri_ready : disp;
    e_deq   = disp;
    e_start = disp ? N'(1 << sel) : '0;
    if (disp) begin
      e_tri = tri_data;
      m_ptr = (sel + 1) % N;
    end
    if (clear) begin
      m_count = disp ? 1 : 0;
      m_eos   = 1'b0;
      m_fd    = 1'b0;
    end else begin
      m_count = (m_count + (disp ? 1 : 0)) % (1 << CW);
      m_eos   = m_eos | eos;
      m_fd    = m_fd | drained;
    end
    if (disp) begin
      n_disp++;
      $display("dispatch %0d: engine %0d, count %0d, clear %0b", n_disp, sel, m_count, clear);
    end
  endtask

  task automatic check_outputs(input string phase);
    check_val({phase, ":dequeue"},    TW'(dequeue),    TW'(e_deq));
    check_val({phase, ":rast_start"}, TW'(rast_start), TW'(e_start));
    check_val({phase, ":rast_tri"},   rast_tri,        e_tri);
    check_val({phase, ":tri_count"},  TW'(tri_count),  TW'(m_count));
    check_val({phase, ":frame_done"}, TW'(frame_done), TW'(m_fd));
  endtask

  task automatic check_all_zero(input string phase);
    check_val({phase, ":dequeue"},    TW'(dequeue),    '0);
    check_val({phase, ":rast_start"}, TW'(rast_start), '0);
    check_val({phase, ":rast_tri"},   rast_tri,        '0);
    check_val({phase, ":tri_count"},  TW'(tri_count),  '0);
    check_val({phase, ":frame_done"}, TW'(frame_done), '0);
  endtask

  initial begin
    rst       = 1'b1;
    tri_ready = 1'b0;
    tri_data  = '0;
    rast_busy = '0;
    eos       = 1'b0;
    clear     = 1'b0;
    deq_pend  = 1'b0;
    gap       = 0;
    rst_hold  = 0;
    for (int e = 0; e < N; e++) begin
      busy_left[e] = 0;
      pend[e]      = 1'b0;
    end
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      check_outputs("cycle");

      // Engines: a start seen now is latched at the next edge, so busy
      // appears one cycle later and holds for a random duration.
      for (int e = 0; e < N; e++) begin
        if (pend[e]) begin
          busy_left[e] = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 30) : $urandom_range(1, 12);
          pend[e] = 1'b0;
        end
        rast_busy[e] = (busy_left[e] > 0);
        if (busy_left[e] > 0) busy_left[e]--;
        if (rast_start[e]) pend[e] = 1'b1;
      end

      // Assembler: releases its triangle the cycle after dequeue, then
      // refetches after a random gap (occasionally long enough to drain).
      if (deq_pend) begin
        tri_ready = 1'b0;
        deq_pend  = 1'b0;
        gap = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 3);
      end else if (!tri_ready) begin
        if (gap == 0) begin
          tri_ready = 1'b1;
          tri_data  = rand_tri();
        end else begin
          gap--;
        end
      end
      if (dequeue) deq_pend = 1'b1;

      eos   = ($urandom_range(0, 39) == 0);
      clear = ($urandom_range(0, 79) == 0);

      // Occasional asynchronous reset mid-cycle; strobes seen this cycle
      // vanish before any edge, so the environment must not act on them.
      if (rst) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b0;
      end else if (cyc > 10 && $urandom_range(0, 299) == 0) begin
        rst      = 1'b1;
        rst_hold = $urandom_range(1, 3);
        deq_pend = 1'b0;
        for (int e = 0; e < N; e++) pend[e] = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
      end

      @(posedge clk);
      if (rst) model_reset();
      else     model_update();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
